dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (combinational read, write on clk edge) between
//  two requesters: port 0 = CPU MEM stage, port 1 = secondary master (debug loader/DMA).
//  Registered grant, one access per cycle, round-robin fairness, req/ack handshake.
//  Sits between the pipeline MEM stage and the data memory; drives its addr/we/wdata.
// PARAMETERS
//  ADDR_W   32  byte-address width of requester and memory-side address buses
//  DATA_W   32  data width
//  CNT_W    16  width of the saturating contention counter
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  req0_i       in   1       port 0 request; held with we/addr/wdata stable until ack0_o
//  we0_i        in   1       port 0 write enable (1=store, 0=load)
//  addr0_i      in   ADDR_W  port 0 byte address (word aligned)
//  wdata0_i     in   DATA_W  port 0 store data
//  ack0_o       out  1       port 0 access performed this cycle (1-cycle pulse)
//  rdata0_o     out  DATA_W  port 0 load data, valid while ack0_o=1
//  stall0_o     out  1       req0_i & ~ack0_o; feeds pipeline stall logic
//  req1_i/we1_i/addr1_i/wdata1_i/ack1_o/rdata1_o   same meanings for port 1
//  dmem_addr_o  out  ADDR_W  memory address (memory indexes with bits [15:2])
//  dmem_we_o    out  1       memory write enable
//  dmem_wdata_o out  DATA_W  memory write data
//  dmem_rdata_i in   DATA_W  memory combinational read data
//  contend_o    out  CNT_W   cycles where both ports requested and one was refused
// BEHAVIOUR
//  - Reset values: grant=NONE, rr_last=1 (port 0 wins first tie), all acks 0,
//    dmem_we_o 0, dmem_addr_o/dmem_wdata_o 0, contend_o 0, rdata*_o 0.
//  - State: grant register {NONE, G0, G1}. Memory side is a mux of the granted port;
//    in NONE, dmem_we_o=0 and addr/wdata=0.
//  - Latency: req sampled at edge N -> grant at N -> ackK_o=1 during cycle N+1,
//    dmem driven by port K during N+1, store written at edge N+2... i.e. the edge ending N+1.
//  - ackK_o = (grant==GK); dmem_we_o = weK_i & ackK_o. rdataK_o = dmem_rdata_i when
//    ackK_o=1, else 0.
//  - Next grant: eligible_k = req_k & ~ack_k (port acked this cycle is ignored, it drops
//    req after ack). One eligible -> grant it. Both -> port != rr_last. None -> NONE.
//  - rr_last updated to K at each edge where ackK_o=1.
//  - Back-to-back: alternating ports get ack every cycle; a single port alone gets at most
//    one ack per two cycles.
//  - contend_o increments at edge when eligible_0 & eligible_1; saturates at all-ones.
//  - Requester dropping req before ack: grant already issued still performs the access
//    using the current (dropped) port inputs with we gated by req (no write if req=0);
//    ack still pulses. Bench treats this as illegal stimulus; no write must occur.
//  - Reset mid-access: grant forced NONE asynchronously, dmem_we_o drops immediately; the
//    interrupted write does not occur; requesters re-arbitrate after reset release.
// CONFIGURATION
//  DMEM_ARB_CPU_PRIO_EN defined: fixed priority, port 0 always wins ties; rr_last kept but
//    unused; port 1 served only when port 0 not eligible.
//  Undefined (default): round-robin as above.
// TESTING
//  1 Reset: rst=1 -> ack0/ack1=0, dmem_we_o=0, contend_o=0, grant NONE.
//  2 Port0 store: req0=1,we0=1,addr0=0x10,wdata0=0xDEADBEEF -> ack0 next cycle,
//    dmem_addr_o=0x10, dmem_we_o=1; later port0 load of 0x10 -> rdata0_o=0xDEADBEEF.
//  3 Both req loads held: acks alternate 0,1,0,1 every cycle; contend_o +1 per cycle
//    both eligible; stall0_o high in port-1 cycles.
//  4 Port1 alone, req held 6 cycles: ack1 on cycles 1,3,5 only.
//  5 With DMEM_ARB_CPU_PRIO_EN, req0 re-raised every other cycle, req1 held: port0 wins
//    every tie; port1 acked only in cycles where port0 ineligible.
//  6 rst pulsed during granted store: dmem_we_o falls same cycle, memory word unchanged;
//    contend_o at 0xFFFF with further contention stays 0xFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: registered grant, req/ack handshake.
// Define DMEM_ARB_CPU_PRIO_EN for fixed port-0 priority; round-robin otherwise.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              stall0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic [CNT_W-1:0]  contend_o
);

    typedef enum logic [1:0] {
        NONE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } grant_e;

    grant_e           grant_q, grant_d;
    logic             rr_last_q, rr_last_d;
    logic [CNT_W-1:0] contend_q, contend_d;
    logic             elig0, elig1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= NONE;
            rr_last_q <= 1'b1;
            contend_q <= '0;
        end else begin
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            contend_q <= contend_d;
        end
    end

    always_comb begin
        // A port acked this cycle drops its request after the ack, so it is not re-eligible.
        elig0   = req0_i & (grant_q != G0);
        elig1   = req1_i & (grant_q != G1);
        grant_d = NONE;
`ifdef DMEM_ARB_CPU_PRIO_EN
        if (elig0)
            grant_d = G0;
        else if (elig1)
            grant_d = G1;
`else
        if (elig0 && elig1)
            grant_d = rr_last_q ? G0 : G1;
        else if (elig0)
            grant_d = G0;
        else if (elig1)
            grant_d = G1;
`endif
        rr_last_d = rr_last_q;
        if (grant_q == G0)
            rr_last_d = 1'b0;
        else if (grant_q == G1)
            rr_last_d = 1'b1;
        contend_d = contend_q;
        if (elig0 && elig1 && (contend_q != '1))
            contend_d = contend_q + CNT_W'(1);
    end

    always_comb begin
        ack0_o       = (grant_q == G0);
        ack1_o       = (grant_q == G1);
        dmem_addr_o  = '0;
        dmem_we_o    = 1'b0;
        dmem_wdata_o = '0;
        // Write is gated by req so a requester that withdrew early never stores.
        unique case (grant_q)
            G0: begin
                dmem_addr_o  = addr0_i;
                dmem_we_o    = we0_i & req0_i;
                dmem_wdata_o = wdata0_i;
            end
            G1: begin
                dmem_addr_o  = addr1_i;
                dmem_we_o    = we1_i & req1_i;
                dmem_wdata_o = wdata1_i;
            end
            default: ;
        endcase
        rdata0_o  = (grant_q == G0) ? dmem_rdata_i : '0;
        rdata1_o  = (grant_q == G1) ? dmem_rdata_i : '0;
        stall0_o  = req0_i & (grant_q != G0);
        contend_o = contend_q;
    end

endmodule
